dr32e_bp_table_arbiter: RTL and testbench

- Controls the single-port branch-prediction table (BHT/BTB SRAM) shared by two requesters: the fetch-stage lookup and the execute-stage resolution update.
- Holds resolved branch updates in a small FIFO and schedules table reads and writes, one access per cycle.
- Runs a clearing sweep after reset or flush, then arbitrates lookups against queued updates.
- Sits between the fetch/execute pipeline and the table SRAM, feeding the branch-predict monitor path.

---
 rtl/dr32e_bp_table_arbiter_if.sv | 37 +++
 rtl/dr32e_bp_table_arbiter.sv | 171 +++++++++++++++++
 tb/tb_dr32e_bp_table_arbiter.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dr32e_bp_table_arbiter_if.sv
// Bus bundle between the fetch/execute pipeline and the branch-prediction
// table arbiter, including the table SRAM access port.
interface dr32e_bp_table_arbiter_if #(
    parameter int IDX_W = 6
);
    logic             flush_i;
    logic             lookup_valid_i;
    logic [31:0]      lookup_pc_i;
    logic             lookup_ready_o;
    logic             lookup_rvalid_o;
    logic             upd_valid_i;
    logic [31:0]      upd_pc_i;
    logic             upd_taken_i;
    logic [31:0]      upd_target_i;
    logic             upd_ready_o;
    logic             tbl_en_o;
    logic             tbl_we_o;
    logic [IDX_W-1:0] tbl_addr_o;
    logic [33:0]      tbl_wdata_o;
    logic             init_busy_o;

    // Pipeline side: drives requests, observes grants and the table port.
    modport master (
        output flush_i, lookup_valid_i, lookup_pc_i,
               upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
        input  lookup_ready_o, lookup_rvalid_o, upd_ready_o,
               tbl_en_o, tbl_we_o, tbl_addr_o, tbl_wdata_o, init_busy_o
    );

    // Arbiter side.
    modport slave (
        input  flush_i, lookup_valid_i, lookup_pc_i,
               upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
        output lookup_ready_o, lookup_rvalid_o, upd_ready_o,
               tbl_en_o, tbl_we_o, tbl_addr_o, tbl_wdata_o, init_busy_o
    );
endinterface

// File: rtl/dr32e_bp_table_arbiter.sv
// Branch-prediction table arbiter: clears the single-port BHT/BTB after
// reset/flush, then shares the port between fetch lookups and a small FIFO
// of resolved-branch updates (one access per cycle, full FIFO has priority).
module dr32e_bp_table_arbiter #(
    parameter int IDX_W      = 6,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    dr32e_bp_table_arbiter_if.slave       bus
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] sweep_q, sweep_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             rvalid_q, rvalid_d;

    logic [IDX_W-1:0] fifo_idx_q    [FIFO_DEPTH];
    logic [IDX_W-1:0] fifo_idx_d    [FIFO_DEPTH];
    logic             fifo_taken_q  [FIFO_DEPTH];
    logic             fifo_taken_d  [FIFO_DEPTH];
    logic [31:0]      fifo_target_q [FIFO_DEPTH];
    logic [31:0]      fifo_target_d [FIFO_DEPTH];

    logic             fifo_full;
    logic             fifo_empty;
    logic             upd_ready;
    logic             enq;
    logic             deq;
    logic             lookup_ready;
    logic             tbl_en;
    logic             tbl_we;
    logic [IDX_W-1:0] tbl_addr;
    logic [33:0]      tbl_wdata;

    assign fifo_full  = (count_q == DEPTH_C);
    assign fifo_empty = (count_q == '0);
    assign upd_ready  = (state_q == ST_RUN) && !fifo_full;
    assign enq        = bus.upd_valid_i && upd_ready;

    // Sweep / arbitration: choose this cycle's single table access.
    always_comb begin
        state_d      = state_q;
        sweep_d      = sweep_q;
        rvalid_d     = 1'b0;
        deq          = 1'b0;
        lookup_ready = 1'b0;
        tbl_en       = 1'b0;
        tbl_we       = 1'b0;
        tbl_addr     = '0;
        tbl_wdata    = '0;

        case (state_q)
            ST_INIT: begin
                tbl_en   = 1'b1;
                tbl_we   = 1'b1;
                tbl_addr = sweep_q;
                sweep_d  = sweep_q + 1'b1;
                if (sweep_q == '1) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (fifo_full) begin
                    deq = 1'b1;
                end else if (bus.lookup_valid_i) begin
                    tbl_en       = 1'b1;
                    tbl_addr     = bus.lookup_pc_i[IDX_W+1:2];
                    lookup_ready = 1'b1;
                    rvalid_d     = 1'b1;
                end else if (!fifo_empty) begin
                    deq = 1'b1;
                end
                if (deq) begin
                    tbl_en    = 1'b1;
                    tbl_we    = 1'b1;
                    tbl_addr  = fifo_idx_q[rd_ptr_q];
                    tbl_wdata = {1'b1, fifo_taken_q[rd_ptr_q], fifo_target_q[rd_ptr_q]};
                end
            end
            default: begin
                state_d = ST_INIT;
                sweep_d = '0;
            end
        endcase

        // The access driven above still happens; only the next state restarts.
        if (bus.flush_i) begin
            state_d  = ST_INIT;
            sweep_d  = '0;
            rvalid_d = 1'b0;
        end
    end

    // Update FIFO: enqueue accepted updates, dequeue on scheduled writes.
    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        fifo_idx_d    = fifo_idx_q;
        fifo_taken_d  = fifo_taken_q;
        fifo_target_d = fifo_target_q;

        if (enq) begin
            fifo_idx_d[wr_ptr_q]    = bus.upd_pc_i[IDX_W+1:2];
            fifo_taken_d[wr_ptr_q]  = bus.upd_taken_i;
            fifo_target_d[wr_ptr_q] = bus.upd_target_i;
            wr_ptr_d                = wr_ptr_q + 1'b1;
        end
        if (deq) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({enq, deq})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Flush drops both the queue contents and any enqueue offered now.
        if (bus.flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    // Control state register; reset overrides flush.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_INIT;
            sweep_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sweep_q  <= sweep_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rvalid_q <= rvalid_d;
        end
    end

    // FIFO payload storage; validity is tracked by count, so no reset needed.
    always_ff @(posedge clk_i) begin
        fifo_idx_q    <= fifo_idx_d;
        fifo_taken_q  <= fifo_taken_d;
        fifo_target_q <= fifo_target_d;
    end

    assign bus.lookup_ready_o  = lookup_ready;
    assign bus.lookup_rvalid_o = rvalid_q;
    assign bus.upd_ready_o     = upd_ready;
    assign bus.tbl_en_o        = tbl_en;
    assign bus.tbl_we_o        = tbl_we;
    assign bus.tbl_addr_o      = tbl_addr;
    assign bus.tbl_wdata_o     = tbl_wdata;
    assign bus.init_busy_o     = (state_q == ST_INIT);

endmodule

// File: tb/tb_dr32e_bp_table_arbiter.sv
// Bench for dr32e_bp_table_arbiter (IDX_W=4, FIFO_DEPTH=4): directed vectors
// with literal expectations plus a queue-based reference model checked on
// every falling edge.
module tb_dr32e_bp_table_arbiter;
    localparam int IDX_W = 4;
    localparam int DEPTH = 4;
    localparam int NENT  = 1 << IDX_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dr32e_bp_table_arbiter_if #(.IDX_W(IDX_W)) bus ();

    dr32e_bp_table_arbiter #(.IDX_W(IDX_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
    } upd_t;

    upd_t mq[$];
    bit   m_init    = 1'b1;
    int   m_sweep   = 0;
    bit   m_rvalid  = 1'b0;
    bit   m_started = 1'b0;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % NENT);
    endfunction

    always @(posedge clk) begin
        bit grant;
        grant = 1'b0;
        if (rst || bus.flush_i) begin
            m_init  = 1'b1;
            m_sweep = 0;
            mq.delete();
        end else if (m_init) begin
            if (m_sweep == NENT - 1) m_init = 1'b0;
            m_sweep = (m_sweep + 1) % NENT;
        end else begin
            bit full;
            bit take;
            full  = (mq.size() == DEPTH);
            grant = !full && bus.lookup_valid_i;
            take  = full || (!bus.lookup_valid_i && mq.size() > 0);
            if (take) void'(mq.pop_front());
            if (bus.upd_valid_i && !full) begin
                upd_t u;
                u.pc = bus.upd_pc_i; u.taken = bus.upd_taken_i; u.target = bus.upd_target_i;
                mq.push_back(u);
            end
        end
        m_rvalid  = grant;
        m_started = 1'b1;
    end

    // Compare all outputs against the model mid-cycle.
    always @(negedge clk) begin
        if (m_started) begin
            logic        e_en, e_we, e_lr;
            int          e_addr;
            logic [33:0] e_wd;
            e_en = 1'b0; e_we = 1'b0; e_lr = 1'b0; e_addr = 0; e_wd = '0;
            if (m_init) begin
                e_en = 1'b1; e_we = 1'b1; e_addr = m_sweep;
            end else if (mq.size() == DEPTH || (!bus.lookup_valid_i && mq.size() > 0)) begin
                e_en = 1'b1; e_we = 1'b1; e_addr = idx_of(mq[0].pc);
                e_wd = {1'b1, mq[0].taken, mq[0].target};
            end else if (bus.lookup_valid_i) begin
                e_en = 1'b1; e_lr = 1'b1; e_addr = idx_of(bus.lookup_pc_i);
            end
            chk("m_en", 64'(bus.tbl_en_o), 64'(e_en));
            chk("m_lookup_ready", 64'(bus.lookup_ready_o), 64'(e_lr));
            chk("m_rvalid", 64'(bus.lookup_rvalid_o), 64'(m_rvalid));
            chk("m_upd_ready", 64'(bus.upd_ready_o), 64'(!m_init && mq.size() < DEPTH));
            chk("m_init_busy", 64'(bus.init_busy_o), 64'(m_init));
            if (e_en) begin
                chk("m_we", 64'(bus.tbl_we_o), 64'(e_we));
                chk("m_addr", 64'(bus.tbl_addr_o), 64'(e_addr));
                if (e_we) chk("m_wdata", 64'(bus.tbl_wdata_o), 64'(e_wd));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic set_upd(input logic v, input logic [31:0] pc, input logic tk, input logic [31:0] tg);
        bus.upd_valid_i  = v;
        bus.upd_pc_i     = pc;
        bus.upd_taken_i  = tk;
        bus.upd_target_i = tg;
    endtask

    initial begin
        bus.flush_i        = 1'b0;
        bus.lookup_valid_i = 1'b0;
        bus.lookup_pc_i    = '0;
        set_upd(1'b0, '0, 1'b0, '0);
        next();
        next();
        #1;
        chk("rst_busy", 64'(bus.init_busy_o), 64'd1);
        chk("rst_upd_ready", 64'(bus.upd_ready_o), 64'd0);
        chk("rst_rvalid", 64'(bus.lookup_rvalid_o), 64'd0);
        rst = 1'b0;

        // 1: full clearing sweep, 16 cycles
        for (int i = 0; i < NENT; i++) begin
            #1;
            chk("sweep_busy", 64'(bus.init_busy_o), 64'd1);
            chk("sweep_addr", 64'(bus.tbl_addr_o), 64'(i));
            chk("sweep_we", 64'(bus.tbl_we_o), 64'd1);
            chk("sweep_wdata", 64'(bus.tbl_wdata_o), 64'd0);
            next();
        end
        #1;
        chk("post_sweep_busy", 64'(bus.init_busy_o), 64'd0);
        chk("post_sweep_upd_ready", 64'(bus.upd_ready_o), 64'd1);

        // 2: single lookup
        bus.lookup_valid_i = 1'b1;
        bus.lookup_pc_i    = 32'h0000_0024;
        #1;
        chk("lk_ready", 64'(bus.lookup_ready_o), 64'd1);
        chk("lk_addr", 64'(bus.tbl_addr_o), 64'd9);
        chk("lk_we", 64'(bus.tbl_we_o), 64'd0);
        next();
        bus.lookup_valid_i = 1'b0;
        #1;
        chk("lk_rvalid", 64'(bus.lookup_rvalid_o), 64'd1);
        next();

        // 3: lookups starve the FIFO until it is full
        bus.lookup_valid_i = 1'b1;
        bus.lookup_pc_i    = 32'h0000_0040;
        for (int k = 0; k < 4; k++) begin
            set_upd(1'b1, 32'h10 + 32'(4 * k), (k % 2) == 0, 32'h100 + 32'(k));
            #1;
            chk("fill_lk_ready", 64'(bus.lookup_ready_o), 64'd1);
            next();
        end
        set_upd(1'b0, '0, 1'b0, '0);
        #1;
        chk("full_upd_ready", 64'(bus.upd_ready_o), 64'd0);
        chk("full_lk_ready", 64'(bus.lookup_ready_o), 64'd0);
        chk("full_we", 64'(bus.tbl_we_o), 64'd1);
        chk("full_addr", 64'(bus.tbl_addr_o), 64'd4);
        chk("full_wdata", 64'(bus.tbl_wdata_o), 64'h3_0000_0100);
        next();
        #1;
        chk("after_full_lk_ready", 64'(bus.lookup_ready_o), 64'd1);
        next();
        bus.lookup_valid_i = 1'b0;
        for (int k = 1; k < 4; k++) begin
            #1;
            chk("drain_addr", 64'(bus.tbl_addr_o), 64'(4 + k));
            chk("drain_wdata", 64'(bus.tbl_wdata_o), {30'd0, 1'b1, ((k % 2) == 0), 32'h100 + 32'(k)});
            next();
        end
        #1;
        chk("drained_idle_en", 64'(bus.tbl_en_o), 64'd0);

        // 4: steady state enqueue + dequeue with two entries held
        bus.lookup_valid_i = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (c == 2) bus.lookup_valid_i = 1'b0;
            if (c < 6) set_upd(1'b1, 32'h20 + 32'(4 * c), 1'b0, 32'h300 + 32'(c));
            else       set_upd(1'b0, '0, 1'b0, '0);
            #1;
            if (c >= 2) begin
                chk("steady_upd_ready", 64'(bus.upd_ready_o), 64'd1);
                chk("steady_addr", 64'(bus.tbl_addr_o), 64'(8 + c - 2));
                chk("steady_we", 64'(bus.tbl_we_o), 64'd1);
            end
            next();
        end
        #1;
        chk("steady_idle_en", 64'(bus.tbl_en_o), 64'd0);

        // 5: flush with three queued entries and an offered update
        bus.lookup_valid_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_upd(1'b1, 32'h30 + 32'(4 * k), 1'b1, 32'h200 + 32'(k));
            next();
        end
        bus.flush_i = 1'b1;
        set_upd(1'b1, 32'h3C, 1'b1, 32'h2FF);
        #1;
        chk("flush_cycle_read", 64'(bus.tbl_we_o), 64'd0);
        next();
        bus.flush_i        = 1'b0;
        bus.lookup_valid_i = 1'b0;
        set_upd(1'b0, '0, 1'b0, '0);
        for (int i = 0; i < NENT; i++) begin
            #1;
            chk("resweep_addr", 64'(bus.tbl_addr_o), 64'(i));
            chk("resweep_wdata", 64'(bus.tbl_wdata_o), 64'd0);
            chk("resweep_rvalid", 64'(bus.lookup_rvalid_o), 64'd0);
            next();
        end
        #1;
        chk("post_flush_idle_en", 64'(bus.tbl_en_o), 64'd0);
        chk("post_flush_upd_ready", 64'(bus.upd_ready_o), 64'd1);

        // 6: reset together with flush in the middle of a sweep
        bus.flush_i = 1'b1;
        next();
        bus.flush_i = 1'b0;
        for (int i = 0; i < 7; i++) next();
        #1;
        chk("mid_sweep_addr", 64'(bus.tbl_addr_o), 64'd7);
        rst         = 1'b1;
        bus.flush_i = 1'b1;
        next();
        #1;
        chk("rst_mid_busy", 64'(bus.init_busy_o), 64'd1);
        chk("rst_mid_addr", 64'(bus.tbl_addr_o), 64'd0);
        chk("rst_mid_rvalid", 64'(bus.lookup_rvalid_o), 64'd0);
        chk("rst_mid_upd_ready", 64'(bus.upd_ready_o), 64'd0);
        rst         = 1'b0;
        bus.flush_i = 1'b0;
        for (int i = 0; i < NENT; i++) next();
        bus.lookup_valid_i = 1'b1;
        bus.lookup_pc_i    = 32'h0000_003C;
        #1;
        chk("final_lk_addr", 64'(bus.tbl_addr_o), 64'd15);
        next();
        bus.lookup_valid_i = 1'b0;
        #1;
        chk("final_rvalid", 64'(bus.lookup_rvalid_o), 64'd1);
        next();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
